// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver types, default rates and ASCII command codes
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} uart_rx_state_t;
  localparam int DEF_CLK_FREQ = 100_000_000;
  localparam int DEF_BAUD = 9600;
  localparam logic [7:0] CMD_X = 8'h58;
  localparam logic [7:0] CMD_O = 8'h4F;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] CMD_1 = 8'h31;
  localparam logic [7:0] CMD_2 = 8'h32;
  localparam logic [7:0] CMD_3 = 8'h33;
  localparam logic [7:0] CMD_4 = 8'h34;
  localparam logic [7:0] CMD_5 = 8'h35;
  localparam logic [7:0] CMD_6 = 8'h36;
  localparam logic [7:0] CMD_7 = 8'h37;
  localparam logic [7:0] CMD_8 = 8'h38;
  localparam logic [7:0] CMD_9 = 8'h39;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous single-bit input
//   clk   in  system clock
//   reset in  asynchronous active-low reset, loads RST_VAL into both flops
//   d     in  asynchronous input
//   q     out synchronized output
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) {q, meta} <= {2{RST_VAL}};
    else {q, meta} <= {meta, d};
  end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a one-entry valid/ready output buffer
//   clk       in  system clock
//   reset     in  asynchronous active-low reset
//   RsRx      in  asynchronous serial line, idles high
//   rx_data   out received byte, valid while rx_valid
//   rx_valid  out buffered byte available
//   rx_ready  in  consumer accepts the byte
//   frame_err out one-cycle pulse on a low stop bit
//   overrun   out one-cycle pulse when a completed byte is dropped
//   busy      out receiver FSM not idle
module uart_rx import uart_pkg::*; #(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int BAUD = DEF_BAUD,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 RsRx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  uart_rx_state_t state, next;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic rx_s, half, tick, last, done, ferr;
  sync_2ff #(.RST_VAL(1'b1)) u_sync (.clk(clk), .reset(reset), .d(RsRx), .q(rx_s));
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= next;
  end
  always_comb begin
    next = state;
    case (state)
      IDLE:      next = rx_s ? IDLE : START;
      START:     next = half ? (rx_s ? IDLE : DATA) : START;
      DATA:      next = (tick && last) ? STOP : DATA;
      STOP:      next = tick ? (rx_s ? IDLE : WAIT_IDLE) : STOP;
      WAIT_IDLE: next = rx_s ? IDLE : WAIT_IDLE;
      default:   next = IDLE;
    endcase
  end
  always_comb begin
    half = cnt == CW'(HALF_BIT - 1);
    tick = cnt == CW'(CLKS_PER_BIT - 1);
    last = bit_idx == BW'(DATA_BITS - 1);
    done = state == STOP && tick && rx_s;
    ferr = state == STOP && tick && !rx_s;
    busy = state != IDLE;
  end
  // cnt restarts at the mid-start sample so every later tick lands mid-bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      bit_idx <= '0;
      shreg <= '0;
    end else begin
      cnt <= (state == IDLE || state == WAIT_IDLE || (state == START && half) || tick) ? '0 : cnt + 1'b1;
      bit_idx <= (state == START && half) ? '0 : (state == DATA && tick && !last) ? bit_idx + 1'b1 : bit_idx;
      if (state == DATA && tick) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
    end
  end
  // a completed byte may replace the buffered one only when it is being accepted this cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data <= '0;
      rx_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      frame_err <= ferr;
      overrun <= done && rx_valid && !rx_ready;
      if (done && (!rx_valid || rx_ready)) begin
        rx_data <= shreg;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) rx_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx with a byte scoreboard
module tb_uart_rx;
  import uart_pkg::*;
  localparam int CPB = 16;
  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         hold_low;
  } vec_t;
  logic clk = 1'b0, reset = 1'b1, RsRx = 1'b1, rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic rx_valid, frame_err, overrun, busy;
  int checks = 0, errors = 0, pops = 0, ferr_cnt = 0, ov_cnt = 0;
  logic [7:0] exp_q[$];
  vec_t vecs[5];

  uart_rx #(.CLK_FREQ(160), .BAUD(10), .DATA_BITS(8)) dut (
    .clk(clk), .reset(reset), .RsRx(RsRx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    RsRx = b;
    cyc(CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  always @(negedge clk) begin
    if (frame_err) ferr_cnt++;
    if (overrun) ov_cnt++;
    if (frame_err || overrun) chk("ferr_ovr_exclusive", int'(frame_err && overrun), 0);
    if (rx_valid && rx_ready) begin
      pops++;
      chk("byte_expected", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("rx_data", rx_data, exp_q.pop_front());
    end
  end

  initial begin
    int p0, f0, o0;
    vecs[0] = '{CMD_X, 1'b1, 0};
    vecs[1] = '{CMD_1, 1'b0, 40};
    vecs[2] = '{CMD_2, 1'b1, 0};
    vecs[3] = '{8'h00, 1'b1, 0};
    vecs[4] = '{8'hA5, 1'b1, 0};
    #2 reset = 1'b0;
    cyc(3);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overrun", overrun, 0);
    reset = 1'b1;
    cyc(5);
    rx_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      p0 = pops; f0 = ferr_cnt; o0 = ov_cnt;
      if (vecs[i].stop) exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop);
      if (!vecs[i].stop) begin
        cyc(vecs[i].hold_low);
        chk($sformatf("vec%0d_wait_idle_busy", i), busy, 1);
        RsRx = 1'b1;
      end
      cyc(20);
      chk($sformatf("vec%0d_bytes", i), pops - p0, int'(vecs[i].stop));
      chk($sformatf("vec%0d_frame_err", i), ferr_cnt - f0, int'(!vecs[i].stop));
      chk($sformatf("vec%0d_overrun", i), ov_cnt - o0, 0);
      chk($sformatf("vec%0d_busy", i), busy, 0);
    end
    // back-to-back frames into a full buffer
    rx_ready = 1'b0;
    p0 = pops; o0 = ov_cnt;
    exp_q.push_back(CMD_O);
    send_frame(CMD_O, 1'b1);
    send_frame(CMD_R, 1'b1);
    cyc(20);
    chk("ovr_count", ov_cnt - o0, 1);
    chk("ovr_valid", rx_valid, 1);
    chk("ovr_held_data", rx_data, 8'h4F);
    chk("ovr_no_pop", pops - p0, 0);
    rx_ready = 1'b1;
    cyc(1);
    rx_ready = 1'b0;
    chk("ovr_accept_clears", rx_valid, 0);
    chk("ovr_accept_pop", pops - p0, 1);
    // glitch on idle line
    p0 = pops; f0 = ferr_cnt;
    RsRx = 1'b0;
    cyc(4);
    RsRx = 1'b1;
    cyc(3);
    chk("glitch_busy", busy, 1);
    cyc(20);
    chk("glitch_idle", busy, 0);
    chk("glitch_valid", rx_valid, 0);
    chk("glitch_ferr", ferr_cnt - f0, 0);
    chk("glitch_pops", pops - p0, 0);
    // completion coinciding with acceptance of the held byte
    exp_q.push_back(CMD_X);
    send_frame(CMD_X, 1'b1);
    cyc(10);
    chk("sim_held_valid", rx_valid, 1);
    o0 = ov_cnt;
    exp_q.push_back(CMD_O);
    fork
      send_frame(CMD_O, 1'b1);
      begin
        cyc(154);
        rx_ready = 1'b1;
        cyc(1);
        rx_ready = 1'b0;
      end
    join
    chk("sim_valid", rx_valid, 1);
    chk("sim_data", rx_data, 8'h4F);
    chk("sim_overrun", ov_cnt - o0, 0);
    rx_ready = 1'b1;
    cyc(1);
    chk("sim_drain", rx_valid, 0);
    // reset in the middle of a frame
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", rx_valid, 0);
    chk("mid_rst_data", rx_data, 0);
    chk("mid_rst_ferr", frame_err, 0);
    chk("mid_rst_ovr", overrun, 0);
    RsRx = 1'b1;
    cyc(3);
    reset = 1'b1;
    cyc(5);
    p0 = pops;
    exp_q.push_back(CMD_9);
    send_frame(CMD_9, 1'b1);
    cyc(20);
    chk("post_rst_pop", pops - p0, 1);
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
